// File: rtl/hack_data_memory.sv
// ============================================================================
// Module   : hack_data_memory
// Purpose  : Hack CPU data-memory stage with RAM, screen and keyboard FIFO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hack_data_memory #(
  parameter int KBD_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       addressM,
  input  logic [15:0]       outM,
  input  logic              loadM,
  output logic [15:0]       inM,
  input  logic              key_valid,
  input  logic [15:0]       key_code,
  output logic              key_ready,
  output logic              kbd_overflow,
  output logic [CNT_W-1:0]  kbd_count,
  input  logic [12:0]       scr_addr,
  output logic [15:0]       scr_data
);

  localparam int             c_PTR_W    = (KBD_DEPTH > 1) ? $clog2(KBD_DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_FULL   = CNT_W'(KBD_DEPTH);
  localparam logic [15:0]    c_KBD_ADDR = 16'h6000;

  generate
    if (CNT_W != $clog2(KBD_DEPTH) + 1) begin : g_cnt_w_check
      $error("CNT_W must equal log2(KBD_DEPTH)+1");
    end
  endgenerate

  // Storage arrays carry no reset so they map onto block RAM.
  logic [15:0] ram_mem [0:16383];
  logic [15:0] scr_mem [0:8191];
  logic [15:0] kbd_mem [0:KBD_DEPTH-1];

  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        scr_data_q;

  logic w_is_ram;
  logic w_is_scr;
  logic w_is_kbd;
  logic w_not_empty;
  logic w_push;
  logic w_pop;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign w_is_ram    = (addressM[15:14] == 2'b00);
  assign w_is_scr    = (addressM[15:13] == 3'b010);
  assign w_is_kbd    = (addressM == c_KBD_ADDR);
  assign w_not_empty = (count_q != '0);

  assign key_ready = (count_q != c_FULL);
  assign w_push    = key_valid & key_ready & (key_code != 16'h0000);
  // Popping an empty FIFO is a no-op, which also lets a push into an empty FIFO land.
  assign w_pop     = loadM & w_is_kbd & w_not_empty;

  // ---------------------------------------------------------------------------
  // CPU read path (combinational, zero latency)
  // ---------------------------------------------------------------------------
  always_comb begin
    inM = 16'h0000;
    if (w_is_ram) begin
      inM = ram_mem[addressM[13:0]];
    end else if (w_is_scr) begin
      inM = scr_mem[addressM[12:0]];
    end else if (w_is_kbd && w_not_empty) begin
      inM = kbd_mem[rd_ptr_q];
    end
  end

  // ---------------------------------------------------------------------------
  // Array writes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (loadM && w_is_ram) begin
      ram_mem[addressM[13:0]] <= outM;
    end
    if (loadM && w_is_scr) begin
      scr_mem[addressM[12:0]] <= outM;
    end
    if (w_push) begin
      kbd_mem[wr_ptr_q] <= key_code;
    end
  end

  // ---------------------------------------------------------------------------
  // Keyboard FIFO control
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
    end
    count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

    // A zero code is dropped silently, so it never flags an overflow.
    if (key_valid && !key_ready && (key_code != 16'h0000)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      scr_data_q <= 16'h0000;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      // Read-before-write: a same-cycle CPU write is seen one edge later.
      scr_data_q <= scr_mem[scr_addr];
    end
  end

  assign kbd_count    = count_q;
  assign kbd_overflow = overflow_q;
  assign scr_data     = scr_data_q;

endmodule

`default_nettype wire

// File: doc/hack_data_memory.md
Name: hack_data_memory

Overview:
- Data-memory stage directly downstream of the Hack CPU. Consumes addressM/outM/loadM and returns inM.
- Decodes the Hack memory map:
  - RAM at 0x0000-0x3FFF
  - screen buffer at 0x4000-0x5FFF
  - keyboard register at 0x6000
- Keyboard is backed by a small FIFO with a valid/ready push handshake; the CPU pops it by writing to 0x6000.
- A second, registered read port on the screen buffer feeds the display controller.

Parameters:
- KBD_DEPTH, 4, keyboard FIFO depth in entries (power of two, 2..16).
- CNT_W, 3, width of kbd_count; must equal log2(KBD_DEPTH)+1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- addressM  input  16  CPU data address
- outM  input  16  CPU write data
- loadM  input  1  CPU write enable
- inM  output  16  read data to CPU (combinational from addressM)
- key_valid  input  1  keyboard source offers key_code
- key_code  input  16  scan code; 0 is reserved and never pushed
- key_ready  output  1  FIFO can accept; push occurs when key_valid & key_ready & key_code!=0
- kbd_overflow  output  1  sticky: key_valid seen while FIFO full
- kbd_count  output  CNT_W  current FIFO occupancy
- scr_addr  input  13  display read address (screen word index)
- scr_data  output  16  display read data, registered

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Asserting reset clears FIFO pointers/count, kbd_overflow and scr_data to 0.
  - After reset, key_ready=1, kbd_count=0, and a read of 0x6000 returns 0.
  - RAM and screen array contents are not reset.
  - Reset during a push or pop discards that operation.
- Address decode:
  - RAM when addressM[15:14]==2'b00.
  - Screen when addressM[15:13]==3'b010; index is addressM[12:0].
  - KBD when addressM==16'h6000.
  - Every other address is unmapped.
- inM is combinational, with zero latency, so the single-cycle CPU sees it in the same cycle.
  - RAM/screen: current array word.
  - KBD: FIFO head when count>0, else 16'h0000.
  - Unmapped: 16'h0000.
- Writes happen on the rising edge when loadM=1.
  - RAM/screen: the word is written.
  - KBD: the FIFO is popped, and the outM value is ignored. A pop when empty is a no-op.
  - Unmapped: the write is ignored.
- Read during write, same address, same cycle: inM shows the old value; the new value is visible from the next cycle.
- Keyboard FIFO:
  - key_ready = (count != KBD_DEPTH).
  - Push and pop in the same cycle when 0<count<DEPTH: count is unchanged and the head advances.
  - Push when empty with a simultaneous pop: the pop is a no-op and the push lands, so count becomes 1.
  - When full, a push is refused even if a pop happens in the same cycle (key_ready is already 0). kbd_overflow is set whenever key_valid=1 and key_ready=0.
  - key_code==0 with key_valid=1 is dropped silently: no push, no overflow.
  - Pointers wrap modulo KBD_DEPTH.
- Screen display port:
  - scr_data <= screen[scr_addr] every rising edge, giving 1-cycle latency.
  - If the CPU writes the same word in the same cycle, scr_data returns the old value (read-before-write).

Test Plan:
- Reset, then CPU writes 16'h1234 to 0x0005. In the write cycle inM shows the old value; the next cycle addressM=0x0005 gives inM=16'h1234. Reading 0x7FFF gives 0, and a write to 0x7FFF changes nothing.
- Write 16'hBEEF to 0x4010 with scr_addr=13'h0010 in the same cycle. scr_data returns the old word one edge later, then 16'hBEEF on the following edge.
- Push keys 0x41, 0x42. Reading 0x6000 gives 0x41 and kbd_count=2. A write to 0x6000 then gives 0x42 and count=1; a second write gives 0 and count=0. A further write leaves count at 0.
- Push 4 keys (fills FIFO): key_ready=0. key_valid=1 with 0x99 sets kbd_overflow=1 and count stays 4. A simultaneous pop plus push of 0x99 leaves count=3 and 0x99 absent.
- Offer key_code=0 with key_valid=1: count and overflow are unchanged. Push while empty with a concurrent KBD write: count=1 and head is the pushed code.
- Assert reset asynchronously mid-cycle with FIFO count=3 and overflow=1. Count, overflow and scr_data clear immediately, without waiting for a clock edge. RAM word 0x0005 still reads 16'h1234 after release.
